// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the core sequencer: controller states, default
// final-instruction index and register-index width.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    BRANCH     = 2'd2,
    DONE       = 2'd3
  } pipe_state_t;

  localparam int FINAL_PC_DEF = 35;
  localparam int REG_W        = 5;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard detector: decode reads a register that the load now in
// execute has not yet written.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic             dec_valid,
  input  logic [REG_W-1:0] dec_rs1,
  input  logic [REG_W-1:0] dec_rs2,
  input  logic             dec_uses_rs1,
  input  logic             dec_uses_rs2,
  input  logic             ex_valid,
  input  logic             ex_load,
  input  logic [REG_W-1:0] ex_rd,
  output logic             lu
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = dec_uses_rs1 && (dec_rs1 == ex_rd);
  assign rs2_hit = dec_uses_rs2 && (dec_rs2 == ex_rd);

  // x0 is hardwired to zero, so a load targeting it never creates a dependency
  assign lu = ex_valid && ex_load && dec_valid && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Central sequencer for the fetch/decode/execute/write core: owns the fetch
// PC, drives stage enables and resolves load-use and branch hazards.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [PC_W-1:0] FINAL_PC = PC_W'(FINAL_PC_DEF),
  parameter int unsigned     CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             DEC_VALID,
  input  logic             DEC_BRANCH,
  input  logic [REG_W-1:0] DEC_RS1,
  input  logic [REG_W-1:0] DEC_RS2,
  input  logic             DEC_USES_RS1,
  input  logic             DEC_USES_RS2,
  input  logic             EX_VALID,
  input  logic             EX_LOAD,
  input  logic [REG_W-1:0] EX_RD,
  input  logic             EX_REDIRECT,
  input  logic [PC_W-1:0]  EX_TARGET,
  input  logic             WB_VALID,
  input  logic [PC_W-1:0]  WB_PC,
  output logic [PC_W-1:0]  PC,
  output logic             FETCH_EN,
  output logic             DECODER_ENABLED,
  output logic             EXECUTER_ENABLED,
  output logic             WRITER_ENABLED,
  output logic             FLUSH_D,
  output logic             COMPLETED,
  output logic [CNT_W-1:0] STALL_COUNT
);

  localparam logic [PC_W-1:0]  PC_ONE  = PC_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  pipe_state_t     state;
  pipe_state_t     state_nxt;
  logic [PC_W-1:0] pc_nxt;
  logic            lu;
  logic            retire_final;

  hazard_detect u_hazard_detect (
    .dec_valid    (DEC_VALID),
    .dec_rs1      (DEC_RS1),
    .dec_rs2      (DEC_RS2),
    .dec_uses_rs1 (DEC_USES_RS1),
    .dec_uses_rs2 (DEC_USES_RS2),
    .ex_valid     (EX_VALID),
    .ex_load      (EX_LOAD),
    .ex_rd        (EX_RD),
    .lu           (lu)
  );

  assign retire_final = WB_VALID && (WB_PC == FINAL_PC);

  always_comb begin
    state_nxt        = state;
    pc_nxt           = PC;
    FETCH_EN         = 1'b1;
    DECODER_ENABLED  = 1'b1;
    EXECUTER_ENABLED = 1'b1;
    WRITER_ENABLED   = 1'b1;
    FLUSH_D          = 1'b0;
    unique case (state)
      RUN: begin
        // the load-use check precedes the branch check so a dependent branch stalls first
        if (lu) begin
          FETCH_EN         = 1'b0;
          DECODER_ENABLED  = 1'b0;
          EXECUTER_ENABLED = 1'b0;
          state_nxt        = LOAD_STALL;
        end else begin
          pc_nxt = PC + PC_ONE;
          if (DEC_VALID && DEC_BRANCH) state_nxt = BRANCH;
        end
      end
      LOAD_STALL: begin
        pc_nxt    = PC + PC_ONE;
        state_nxt = RUN;
      end
      BRANCH: begin
        if (!EX_VALID) begin
          FETCH_EN        = 1'b0;
          DECODER_ENABLED = 1'b0;
        end else if (EX_REDIRECT) begin
          pc_nxt    = EX_TARGET;
          FLUSH_D   = 1'b1;
          state_nxt = RUN;
        end else begin
          pc_nxt    = PC + PC_ONE;
          state_nxt = RUN;
        end
      end
      DONE: begin
        FETCH_EN         = 1'b0;
        DECODER_ENABLED  = 1'b0;
        EXECUTER_ENABLED = 1'b0;
        WRITER_ENABLED   = 1'b0;
      end
      default: state_nxt = RUN;
    endcase
    // retirement of the final instruction overrides every other transition and freezes PC
    if (state != DONE && retire_final) begin
      state_nxt = DONE;
      pc_nxt    = PC;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= RUN;
      PC          <= RESET_PC;
      COMPLETED   <= 1'b0;
      STALL_COUNT <= '0;
    end else begin
      state     <= state_nxt;
      PC        <= pc_nxt;
      COMPLETED <= COMPLETED || (state_nxt == DONE);
      if (!FETCH_EN && state != DONE) STALL_COUNT <= sat_inc(STALL_COUNT);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Vector and sequence bench for pipe_ctrl: hazard stalls, branch resolution,
// completion and reset from mid-operation states.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  typedef struct {
    string       nm;
    logic        rst;
    logic        dv, db, u1, u2;
    logic [4:0]  rs1, rs2;
    logic        exv, exl;
    logic [4:0]  rd;
    logic        rdr;
    logic [31:0] tgt;
    logic        wbv;
    logic [31:0] wbpc;
    logic [4:0]  en;
    logic [31:0] pc;
    logic        comp;
    logic [15:0] sc;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic        DEC_VALID, DEC_BRANCH, DEC_USES_RS1, DEC_USES_RS2;
  logic [4:0]  DEC_RS1, DEC_RS2, EX_RD;
  logic        EX_VALID, EX_LOAD, EX_REDIRECT, WB_VALID;
  logic [31:0] EX_TARGET, WB_PC, PC;
  logic        FETCH_EN, DECODER_ENABLED, EXECUTER_ENABLED, WRITER_ENABLED, FLUSH_D, COMPLETED;
  logic [15:0] STALL_COUNT;

  int checks   = 0;
  int failures = 0;
  vec_t vq[$];
  vec_t sb[$];

  pipe_ctrl dut (
    .CLK(CLK), .RST(RST),
    .DEC_VALID(DEC_VALID), .DEC_BRANCH(DEC_BRANCH),
    .DEC_RS1(DEC_RS1), .DEC_RS2(DEC_RS2),
    .DEC_USES_RS1(DEC_USES_RS1), .DEC_USES_RS2(DEC_USES_RS2),
    .EX_VALID(EX_VALID), .EX_LOAD(EX_LOAD), .EX_RD(EX_RD),
    .EX_REDIRECT(EX_REDIRECT), .EX_TARGET(EX_TARGET),
    .WB_VALID(WB_VALID), .WB_PC(WB_PC),
    .PC(PC), .FETCH_EN(FETCH_EN), .DECODER_ENABLED(DECODER_ENABLED),
    .EXECUTER_ENABLED(EXECUTER_ENABLED), .WRITER_ENABLED(WRITER_ENABLED),
    .FLUSH_D(FLUSH_D), .COMPLETED(COMPLETED), .STALL_COUNT(STALL_COUNT)
  );

  always #5 CLK = ~CLK;

  function automatic vec_t mk(input string nm, input logic r, dv, db, u1, input logic [4:0] rs1,
                              input logic u2, input logic [4:0] rs2, input logic exv, exl,
                              input logic [4:0] rd, input logic rdr, input logic [31:0] tgt,
                              input logic wbv, input logic [31:0] wbpc, input logic [4:0] en,
                              input logic [31:0] pc, input logic comp, input logic [15:0] sc);
    vec_t v;
    v.nm = nm; v.rst = r; v.dv = dv; v.db = db; v.u1 = u1; v.rs1 = rs1; v.u2 = u2; v.rs2 = rs2;
    v.exv = exv; v.exl = exl; v.rd = rd; v.rdr = rdr; v.tgt = tgt; v.wbv = wbv; v.wbpc = wbpc;
    v.en = en; v.pc = pc; v.comp = comp; v.sc = sc;
    return v;
  endfunction

  function automatic vec_t idle(input string nm, input logic [4:0] en, input logic [31:0] pc,
                                input logic comp, input logic [15:0] sc);
    return mk(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, en, pc, comp, sc);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic run(input vec_t v);
    vec_t e;
    @(negedge CLK);
    RST = v.rst; DEC_VALID = v.dv; DEC_BRANCH = v.db;
    DEC_USES_RS1 = v.u1; DEC_RS1 = v.rs1; DEC_USES_RS2 = v.u2; DEC_RS2 = v.rs2;
    EX_VALID = v.exv; EX_LOAD = v.exl; EX_RD = v.rd; EX_REDIRECT = v.rdr; EX_TARGET = v.tgt;
    WB_VALID = v.wbv; WB_PC = v.wbpc;
    sb.push_back(v);
    #1;
    chk({sb[0].nm, ".en"}, 32'({FETCH_EN, DECODER_ENABLED, EXECUTER_ENABLED, WRITER_ENABLED, FLUSH_D}),
        32'(sb[0].en));
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    chk({e.nm, ".pc"}, PC, e.pc);
    chk({e.nm, ".completed"}, 32'(COMPLETED), 32'(e.comp));
    chk({e.nm, ".stall_count"}, 32'(STALL_COUNT), 32'(e.sc));
  endtask

  initial begin
    RST = 1'b1; DEC_VALID = 0; DEC_BRANCH = 0; DEC_USES_RS1 = 0; DEC_USES_RS2 = 0;
    DEC_RS1 = 0; DEC_RS2 = 0; EX_VALID = 0; EX_LOAD = 0; EX_RD = 0; EX_REDIRECT = 0;
    EX_TARGET = 0; WB_VALID = 0; WB_PC = 0;
    repeat (2) @(posedge CLK);

    //               nm            r dv db u1 rs1 u2 rs2 exv exl rd rdr tgt wbv wbpc en        pc comp sc
    vq.push_back(mk("reset",       1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 5'b11110, 0, 0, 0));
    vq.push_back(idle("seq1", 5'b11110, 1, 0, 0));
    vq.push_back(idle("seq2", 5'b11110, 2, 0, 0));
    vq.push_back(idle("seq3", 5'b11110, 3, 0, 0));
    vq.push_back(mk("lu_rs2",      0, 1, 0, 0, 0, 1, 14, 1, 1, 14, 0, 0, 0, 0, 5'b00010, 3, 0, 1));
    vq.push_back(mk("lu_release",  0, 1, 0, 0, 0, 1, 14, 0, 0, 0, 0, 0, 0, 0, 5'b11110, 4, 0, 1));
    vq.push_back(idle("after_lu", 5'b11110, 5, 0, 1));
    vq.push_back(mk("lu_rd0",      0, 1, 0, 1, 0, 1, 0,  1, 1, 0, 0, 0, 0, 0, 5'b11110, 6, 0, 1));
    vq.push_back(mk("lu_rs1",      0, 1, 0, 1, 7, 0, 0,  1, 1, 7, 0, 0, 0, 0, 5'b00010, 6, 0, 2));
    vq.push_back(idle("lu_rs1_rel", 5'b11110, 7, 0, 2));
    vq.push_back(idle("seq8", 5'b11110, 8, 0, 2));
    vq.push_back(idle("seq9", 5'b11110, 9, 0, 2));
    vq.push_back(mk("br_dec",      0, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 5'b11110, 10, 0, 2));
    vq.push_back(mk("br_taken",    0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 12, 0, 0, 5'b11111, 12, 0, 2));
    vq.push_back(idle("after_taken", 5'b11110, 13, 0, 2));
    vq.push_back(mk("brnt_dec",    0, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 5'b11110, 14, 0, 2));
    vq.push_back(mk("brnt_res",    0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 99, 0, 0, 5'b11110, 15, 0, 2));
    vq.push_back(mk("brw_dec",     0, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 5'b11110, 16, 0, 2));
    vq.push_back(idle("brw_wait", 5'b00110, 16, 0, 3));
    vq.push_back(mk("brw_res",     0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 5'b11110, 17, 0, 3));
    vq.push_back(mk("brr_dec",     0, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 5'b11110, 18, 0, 3));
    vq.push_back(mk("rst_in_br",   1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 5'b00110, 0, 0, 0));
    vq.push_back(idle("after_rst", 5'b11110, 1, 0, 0));
    vq.push_back(mk("done_vs_br",  0, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 35, 5'b11110, 1, 1, 0));
    vq.push_back(idle("done_idle", 5'b00000, 1, 1, 0));
    vq.push_back(mk("done_haz",    0, 1, 1, 1, 3, 0, 0,  1, 1, 3, 1, 20, 0, 0, 5'b00000, 1, 1, 0));
    vq.push_back(mk("done_wb",     0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 35, 5'b00000, 1, 1, 0));
    vq.push_back(mk("rst_done",    1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0));
    vq.push_back(idle("after_rst2", 5'b11110, 1, 0, 0));
    vq.push_back(mk("wb_other",    0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 34, 5'b11110, 2, 0, 0));
    vq.push_back(mk("wb_novalid",  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 35, 5'b11110, 3, 0, 0));
    vq.push_back(mk("wrap_dec",    0, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 5'b11110, 4, 0, 0));
    vq.push_back(mk("wrap_tgt",    0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 32'hFFFF_FFFF, 0, 0, 5'b11111,
                    32'hFFFF_FFFF, 0, 0));
    vq.push_back(idle("wrap", 5'b11110, 0, 0, 0));

    foreach (vq[i]) run(vq[i]);

    // long unresolved branch: stall counter tracks every waiting cycle
    run(mk("lw_dec", 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11110, 1, 0, 0));
    for (int i = 1; i <= 5; i++) run(idle($sformatf("lw_wait%0d", i), 5'b00110, 1, 0, 16'(i)));
    run(mk("lw_taken", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 40, 0, 0, 5'b11111, 40, 0, 5));

    // branch reading a load result stalls first, then enters branch handling
    run(mk("lub_stall", 0, 1, 1, 1, 3, 0, 0, 1, 1, 3, 0, 0, 0, 0, 5'b00010, 40, 0, 6));
    run(mk("lub_rel",   0, 1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11110, 41, 0, 6));
    run(mk("lub_br",    0, 1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11110, 42, 0, 6));
    run(idle("lub_wait", 5'b00110, 42, 0, 7));
    run(mk("lub_res",   0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 5'b11110, 43, 0, 7));

    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
